// File: rtl/interval_timer_master.sv
`default_nettype none
// ============================================================================
// Module   : interval_timer_master
// Purpose  : Avalon-MM initiator that programs a 16-bit-register interval
//            timer, services each timer IRQ by clearing its status register,
//            and counts serviced ticks.
// Options  : INTERVAL_TIMER_MASTER_SNAPSHOT_EN adds counter snapshot reads
//            (SNAP_* states, snap_value/snap_valid live).
// Revision : 1.0 - initial release
// ============================================================================
module interval_timer_master #(
  parameter int unsigned TICK_W     = 32,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       period_value,
  input  logic              snap_req,
  input  logic              irq,
  output logic [2:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata,
  output logic              running,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              cfg_error,
  output logic [31:0]       snap_value,
  output logic              snap_valid
);

  localparam logic [31:0] c_MIN_PERIOD = 32'(MIN_PERIOD);

  // Timer register map
  localparam logic [2:0] c_A_STATUS = 3'd0;
  localparam logic [2:0] c_A_CTRL   = 3'd1;
  localparam logic [2:0] c_A_PER_LO = 3'd2;
  localparam logic [2:0] c_A_PER_HI = 3'd3;
`ifdef INTERVAL_TIMER_MASTER_SNAPSHOT_EN
  localparam logic [2:0] c_A_SNP_LO = 3'd4;
  localparam logic [2:0] c_A_SNP_HI = 3'd5;
`endif

  localparam logic [3:0] c_ST_IDLE      = 4'd0;
  localparam logic [3:0] c_ST_WR_PL     = 4'd1;
  localparam logic [3:0] c_ST_WR_PH     = 4'd2;
  localparam logic [3:0] c_ST_WR_CTRL   = 4'd3;
  localparam logic [3:0] c_ST_RUN       = 4'd4;
  localparam logic [3:0] c_ST_CLR_STAT  = 4'd5;
  localparam logic [3:0] c_ST_DIS_CTRL  = 4'd6;
`ifdef INTERVAL_TIMER_MASTER_SNAPSHOT_EN
  localparam logic [3:0] c_ST_SNAP_WR   = 4'd7;
  localparam logic [3:0] c_ST_SNAP_RD_L = 4'd8;
  localparam logic [3:0] c_ST_SNAP_RD_H = 4'd9;
  localparam logic [3:0] c_ST_SNAP_CAP  = 4'd10;
`endif

  logic [3:0]        r_state;
  logic [3:0]        w_state_nxt;
  logic [31:0]       r_period;
  logic              r_running;
  logic [TICK_W-1:0] r_tick_count;
  logic              r_cfg_error;
  logic              w_load;
  logic              w_cfg_err;
  logic              w_period_ok;

  assign w_period_ok = (period_value >= c_MIN_PERIOD);

  // State register plus the status registers that change on state exits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_ST_IDLE;
      r_period     <= 32'd0;
      r_running    <= 1'b0;
      r_tick_count <= '0;
      r_cfg_error  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg_error <= w_cfg_err;
      if (w_load)
        r_period <= period_value;
      if (r_state == c_ST_WR_CTRL)
        r_running <= 1'b1;
      else if (r_state == c_ST_DIS_CTRL)
        r_running <= 1'b0;
      if (r_state == c_ST_CLR_STAT)
        r_tick_count <= r_tick_count + TICK_W'(1);
    end
  end

  // Next-state: requests are honoured only in IDLE/RUN; everything else is a fixed sequence
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cfg_err   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        // irq is ignored here: the timer interrupt is disabled while idle
        if (start) begin
          if (w_period_ok) begin
            w_state_nxt = c_ST_WR_PL;
            w_load      = 1'b1;
          end else begin
            w_cfg_err = 1'b1;
          end
        end
      end
      c_ST_WR_PL:   w_state_nxt = c_ST_WR_PH;
      c_ST_WR_PH:   w_state_nxt = c_ST_WR_CTRL;
      c_ST_WR_CTRL: w_state_nxt = c_ST_RUN;
      c_ST_RUN: begin
        if (stop) begin
          w_state_nxt = c_ST_DIS_CTRL;
        end else if (start) begin
          if (w_period_ok) begin
            w_state_nxt = c_ST_WR_PL;
            w_load      = 1'b1;
          end else begin
            w_cfg_err = 1'b1;
          end
        end else if (irq) begin
          w_state_nxt = c_ST_CLR_STAT;
        end
`ifdef INTERVAL_TIMER_MASTER_SNAPSHOT_EN
        else if (snap_req) begin
          w_state_nxt = c_ST_SNAP_WR;
        end
`endif
      end
      // Returning to RUN before re-sampling irq gives the timer a cycle to drop it
      c_ST_CLR_STAT: w_state_nxt = c_ST_RUN;
      c_ST_DIS_CTRL: w_state_nxt = c_ST_IDLE;
`ifdef INTERVAL_TIMER_MASTER_SNAPSHOT_EN
      c_ST_SNAP_WR:   w_state_nxt = c_ST_SNAP_RD_L;
      c_ST_SNAP_RD_L: w_state_nxt = c_ST_SNAP_RD_H;
      c_ST_SNAP_RD_H: w_state_nxt = c_ST_SNAP_CAP;
      c_ST_SNAP_CAP:  w_state_nxt = c_ST_RUN;
`endif
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Bus and strobe outputs decoded from state; forced idle during reset so no access leaks out
  always_comb begin
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_address    = 3'd0;
    av_writedata  = 16'd0;
    tick          = 1'b0;
    busy          = 1'b0;
    snap_valid    = 1'b0;
    if (!reset) begin
      busy = (r_state != c_ST_IDLE) && (r_state != c_ST_RUN);
      case (r_state)
        c_ST_WR_PL: begin
          av_chipselect = 1'b1;
          av_write_n    = 1'b0;
          av_address    = c_A_PER_LO;
          av_writedata  = r_period[15:0];
        end
        c_ST_WR_PH: begin
          av_chipselect = 1'b1;
          av_write_n    = 1'b0;
          av_address    = c_A_PER_HI;
          av_writedata  = r_period[31:16];
        end
        c_ST_WR_CTRL: begin
          av_chipselect = 1'b1;
          av_write_n    = 1'b0;
          av_address    = c_A_CTRL;
          av_writedata  = 16'd1;
        end
        c_ST_CLR_STAT: begin
          av_chipselect = 1'b1;
          av_write_n    = 1'b0;
          av_address    = c_A_STATUS;
          tick          = 1'b1;
        end
        c_ST_DIS_CTRL: begin
          av_chipselect = 1'b1;
          av_write_n    = 1'b0;
          av_address    = c_A_CTRL;
        end
`ifdef INTERVAL_TIMER_MASTER_SNAPSHOT_EN
        c_ST_SNAP_WR: begin
          av_chipselect = 1'b1;
          av_write_n    = 1'b0;
          av_address    = c_A_SNP_LO;
        end
        c_ST_SNAP_RD_L: begin
          av_chipselect = 1'b1;
          av_address    = c_A_SNP_LO;
        end
        c_ST_SNAP_RD_H: begin
          av_chipselect = 1'b1;
          av_address    = c_A_SNP_HI;
        end
        c_ST_SNAP_CAP: snap_valid = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign running    = r_running;
  assign tick_count = r_tick_count;
  assign cfg_error  = r_cfg_error;

`ifdef INTERVAL_TIMER_MASTER_SNAPSHOT_EN
  logic [15:0] r_snap_lo;
  logic [31:0] r_snap_value;

  // Read data trails each read by one cycle: lo lands in SNAP_RD_H, hi in SNAP_CAP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap_lo    <= 16'd0;
      r_snap_value <= 32'd0;
    end else begin
      if (r_state == c_ST_SNAP_RD_H)
        r_snap_lo <= av_readdata;
      if (r_state == c_ST_SNAP_CAP)
        r_snap_value <= {av_readdata, r_snap_lo};
    end
  end

  // Present the fresh value in the same cycle as snap_valid, then hold it
  assign snap_value = snap_valid ? {av_readdata, r_snap_lo} : r_snap_value;
`else
  logic w_unused_snap;
  assign w_unused_snap = ^{snap_req, av_readdata};
  assign snap_value    = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_interval_timer_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_interval_timer_master
// Purpose  : Directed bench for interval_timer_master with a small timer model
//            (level irq cleared by a status write, snapshot read data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_interval_timer_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] period_value = 32'd0;
  logic        snap_req = 1'b0;
  logic        irq;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata = 16'hDEAD;
  logic        running;
  logic        busy;
  logic        tick;
  logic [31:0] tick_count;
  logic        cfg_error;
  logic [31:0] snap_value;
  logic        snap_valid;

  int n_chk  = 0;
  int n_fail = 0;
  int raise_cnt = 0;
  int clr_cnt   = 0;
  int exp_cnt   = 0;

  interval_timer_master #(.TICK_W(32), .MIN_PERIOD(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .period_value(period_value), .snap_req(snap_req), .irq(irq),
    .av_address(av_address), .av_chipselect(av_chipselect),
    .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .running(running), .busy(busy),
    .tick(tick), .tick_count(tick_count), .cfg_error(cfg_error),
    .snap_value(snap_value), .snap_valid(snap_valid)
  );

  always #5 clk = ~clk;

  // Timer model: irq is high while raises outnumber status-register writes
  assign irq = (raise_cnt != clr_cnt);

  always @(posedge clk) begin
    if (av_chipselect && !av_write_n && av_address == 3'd0)
      clr_cnt <= clr_cnt + 1;
    if (av_chipselect && av_write_n)
      av_readdata <= (av_address == 3'd4) ? 16'h1234 :
                     (av_address == 3'd5) ? 16'h00AB : 16'h0000;
    else
      av_readdata <= 16'hDEAD;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bus(input string nm, input logic cs, input logic wn,
                         input logic [2:0] a, input logic [15:0] d);
    chk({nm, ".cs"},   32'(av_chipselect), 32'(cs));
    chk({nm, ".wn"},   32'(av_write_n),    32'(wn));
    chk({nm, ".addr"}, 32'(av_address),    32'(a));
    chk({nm, ".wd"},   32'(av_writedata),  32'(d));
  endtask

  task automatic chk_st(input string nm, input logic run, input logic bsy,
                        input logic tk, input logic cfg, input logic [31:0] cnt);
    chk({nm, ".running"},    32'(running),   32'(run));
    chk({nm, ".busy"},       32'(busy),      32'(bsy));
    chk({nm, ".tick"},       32'(tick),      32'(tk));
    chk({nm, ".cfg_error"},  32'(cfg_error), 32'(cfg));
    chk({nm, ".tick_count"}, tick_count,     cnt);
  endtask

  // Advance to just after the next active edge and drop any pulse inputs
  task automatic next_cyc();
    @(posedge clk);
    #1;
    start    = 1'b0;
    stop     = 1'b0;
    snap_req = 1'b0;
  endtask

  typedef struct {
    logic        start;
    logic        stop;
    logic        raise;
    logic [31:0] period;
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] wd;
    logic        run;
    logic        busy;
    logic        tick;
    logic        cfg;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // inputs applied during the cycle, outputs expected during that same cycle
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'd3,          1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0019_2D4F,  1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 3'd2, 16'h2D4F, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 3'd3, 16'h0019, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 3'd1, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'd0,          1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'd0,          1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'd0,          1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 32'd2};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'd3,          1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'd0,          1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'd3};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'd0,          1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Table: bad start in IDLE, programming, three serviced irqs, bad start in RUN
    for (int i = 0; i < 14; i++) begin
      start        = tbl[i].start;
      stop         = tbl[i].stop;
      period_value = tbl[i].period;
      if (tbl[i].raise) raise_cnt++;
      @(negedge clk);
      chk_bus($sformatf("vec%0d", i), tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd);
      chk_st($sformatf("vec%0d", i), tbl[i].run, tbl[i].busy, tbl[i].tick, tbl[i].cfg, tbl[i].cnt);
      next_cyc();
    end
    exp_cnt = 3;

    // Snapshot request in RUN
    snap_req = 1'b1;
    @(negedge clk);
    next_cyc();
`ifdef INTERVAL_TIMER_MASTER_SNAPSHOT_EN
    raise_cnt++;                       // irq arrives mid-sequence
    @(negedge clk);
    chk_bus("snap_wr", 1'b1, 1'b0, 3'd4, 16'h0000);
    chk("snap_wr.busy", 32'(busy), 32'd1);
    next_cyc();
    @(negedge clk);
    chk_bus("snap_rdl", 1'b1, 1'b1, 3'd4, 16'h0000);
    next_cyc();
    @(negedge clk);
    chk_bus("snap_rdh", 1'b1, 1'b1, 3'd5, 16'h0000);
    chk("snap_rdh.valid", 32'(snap_valid), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("snap_cap.valid", 32'(snap_valid), 32'd1);
    chk("snap_cap.value", snap_value, 32'h00AB_1234);
    chk("snap_cap.cs", 32'(av_chipselect), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("snap_run.valid", 32'(snap_valid), 32'd0);
    chk("snap_run.hold", snap_value, 32'h00AB_1234);
    chk_st("snap_run", 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);
    next_cyc();
    @(negedge clk);
    chk_bus("snap_irq", 1'b1, 1'b0, 3'd0, 16'h0000);
    chk("snap_irq.tick", 32'(tick), 32'd1);
    next_cyc();
    exp_cnt++;
`else
    @(negedge clk);
    chk_bus("nosnap", 1'b0, 1'b1, 3'd0, 16'h0000);
    chk("nosnap.valid", 32'(snap_valid), 32'd0);
    chk("nosnap.value", snap_value, 32'd0);
    next_cyc();
`endif

    // stop and irq in the same RUN cycle: stop wins
    stop = 1'b1;
    raise_cnt++;
    @(negedge clk);
    chk_st("stop_req", 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);
    next_cyc();
    @(negedge clk);
    chk_bus("dis_ctrl", 1'b1, 1'b0, 3'd1, 16'h0000);
    chk_st("dis_ctrl", 1'b1, 1'b1, 1'b0, 1'b0, exp_cnt);
    next_cyc();
    @(negedge clk);
    chk_bus("idle_irq", 1'b0, 1'b1, 3'd0, 16'h0000);
    chk_st("idle_irq", 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
    next_cyc();
    @(negedge clk);
    chk_bus("idle_irq2", 1'b0, 1'b1, 3'd0, 16'h0000);
    chk("idle_irq2.cnt", tick_count, exp_cnt);

    // Restart with the minimum legal period; the pending irq gets serviced once running
    start        = 1'b1;
    period_value = 32'd4;
    next_cyc();
    @(negedge clk);
    chk_bus("min_pl", 1'b1, 1'b0, 3'd2, 16'h0004);
    chk("min_pl.cfg", 32'(cfg_error), 32'd0);
    start = 1'b1;                      // dropped while busy
    period_value = 32'h0000_0100;
    next_cyc();
    @(negedge clk);
    chk_bus("min_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
    next_cyc();
    @(negedge clk);
    chk_bus("min_ctrl", 1'b1, 1'b0, 3'd1, 16'h0001);
    next_cyc();
    @(negedge clk);
    chk_st("min_run", 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);
    next_cyc();
    @(negedge clk);
    chk_bus("min_clr", 1'b1, 1'b0, 3'd0, 16'h0000);
    chk("min_clr.tick", 32'(tick), 32'd1);
    next_cyc();
    exp_cnt++;
    @(negedge clk);
    chk_st("min_after", 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);

    // Reset asserted while in WR_PH
    start        = 1'b1;
    period_value = 32'h0019_2D4F;
    next_cyc();
    @(negedge clk);
    chk_bus("rst_pl", 1'b1, 1'b0, 3'd2, 16'h2D4F);
    next_cyc();
    reset = 1'b1;
    @(negedge clk);
    chk_bus("rst_cycle", 1'b0, 1'b1, 3'd0, 16'h0000);
    chk("rst_cycle.busy", 32'(busy), 32'd0);
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    chk_bus("rst_after", 1'b0, 1'b1, 3'd0, 16'h0000);
    chk_st("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rst_after.valid", 32'(snap_valid), 32'd0);
    chk("rst_after.snap", snap_value, 32'd0);
    next_cyc();
    @(negedge clk);
    chk_bus("rst_idle", 1'b0, 1'b1, 3'd0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
